// File: rtl/synth_voice_pkg.sv
// rtl/synth_voice_pkg.sv - shared types and widths for the voice allocator
// Contents: NOTE_W/OCT_W widths, note_event_t queued event, alloc_state_e FSM states.
package synth_voice_pkg;

  localparam int NOTE_W = 7;
  localparam int OCT_W  = 8;

  typedef struct packed {
    logic              is_trig;
    logic [NOTE_W-1:0] note;
    logic [OCT_W-1:0]  octave;
  } note_event_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } alloc_state_e;

endpackage

// File: rtl/note_event_fifo.sv
// rtl/note_event_fifo.sv - synchronous FIFO of note events
// Ports: Clk, Reset_n (async active-low); push/push_data write side;
//        pop/pop_data read side (pop_data is the head, valid when !empty);
//        full, empty status. A push while full is ignored.
module note_event_fifo
  import synth_voice_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        push,
  input  note_event_t push_data,
  input  logic        pop,
  output note_event_t pop_data,
  output logic        full,
  output logic        empty
);

  localparam int AW = $clog2(DEPTH);

  note_event_t mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-to-voice scheduler
// Ports: Clk, Reset_n (async active-low); noteTrig/noteOff one-cycle events
//        with noteIdx/octave; env_idle per-voice release-finished flags;
//        voice_gate/voice_start/voice_note/voice_octave per-voice outputs;
//        busy (work pending), overflow (sticky, an event was dropped).
module voice_allocator
  import synth_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_W      = 4
) (
  input  logic                                 Clk,
  input  logic                                 Reset_n,
  input  logic                                 noteTrig,
  input  logic                                 noteOff,
  input  logic [NOTE_W-1:0]                    noteIdx,
  input  logic [OCT_W-1:0]                     octave,
  input  logic [NUM_VOICES-1:0]                env_idle,
  output logic [NUM_VOICES-1:0]                voice_gate,
  output logic [NUM_VOICES-1:0]                voice_start,
  output logic [NUM_VOICES-1:0][NOTE_W-1:0]    voice_note,
  output logic [NUM_VOICES-1:0][OCT_W-1:0]     voice_octave,
  output logic                                 busy,
  output logic                                 overflow
);

  localparam int                IW       = $clog2(NUM_VOICES);
  localparam logic [IW-1:0]     LAST_IDX = IW'(NUM_VOICES - 1);
  localparam logic [AGE_W-1:0]  AGE_MAX  = '1;

  alloc_state_e                        state;
  note_event_t                         ev;
  note_event_t                         fifo_in;
  note_event_t                         fifo_out;
  logic                                fifo_push;
  logic                                fifo_pop;
  logic                                fifo_full;
  logic                                fifo_empty;
  logic [IW-1:0]                       idx;
  logic [IW-1:0]                       match_idx;
  logic [IW-1:0]                       free_idx;
  logic [IW-1:0]                       old_idx;
  logic [IW-1:0]                       target;
  logic                                match_ok;
  logic                                free_ok;
  logic [AGE_W-1:0]                    old_age;
  logic [NUM_VOICES-1:0][AGE_W-1:0]    age;

  // A simultaneous note-off is ignored: the event is then a trigger.
  assign fifo_push = noteTrig || noteOff;
  assign fifo_in   = '{is_trig: noteTrig, note: noteIdx, octave: octave};
  assign fifo_pop  = (state == IDLE) && !fifo_empty;
  assign busy      = (state != IDLE) || !fifo_empty;

  note_event_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) overflow <= 1'b0;
    else if (fifo_push && fifo_full) overflow <= 1'b1;
  end

  // Retrigger of a held note wins, then a fully idle voice, then the oldest.
  always_comb begin
    target = old_idx;
    if (free_ok)  target = free_idx;
    if (match_ok) target = match_idx;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      ev           <= '0;
      idx          <= '0;
      match_ok     <= 1'b0;
      free_ok      <= 1'b0;
      match_idx    <= '0;
      free_idx     <= '0;
      old_idx      <= '0;
      old_age      <= '0;
      age          <= '0;
      voice_gate   <= '0;
      voice_start  <= '0;
      voice_note   <= '0;
      voice_octave <= '0;
    end else begin
      voice_start <= '0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            ev        <= fifo_out;
            idx       <= '0;
            match_ok  <= 1'b0;
            free_ok   <= 1'b0;
            match_idx <= '0;
            free_idx  <= '0;
            old_idx   <= '0;
            old_age   <= '0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (!match_ok && voice_gate[idx] && (voice_note[idx] == ev.note)) begin
            match_ok  <= 1'b1;
            match_idx <= idx;
          end
          // Releasing voices (gate low, envelope still running) are not free.
          if (!free_ok && !voice_gate[idx] && env_idle[idx]) begin
            free_ok  <= 1'b1;
            free_idx <= idx;
          end
          // Strictly greater keeps the lowest index on equal ages.
          if (age[idx] > old_age) begin
            old_age <= age[idx];
            old_idx <= idx;
          end
          if (idx == LAST_IDX) state <= COMMIT;
          else                 idx   <= idx + 1'b1;
        end
        COMMIT: begin
          if (ev.is_trig) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              if (IW'(i) == target) begin
                voice_gate[i]   <= 1'b1;
                voice_note[i]   <= ev.note;
                voice_octave[i] <= ev.octave;
                age[i]          <= '0;
                voice_start[i]  <= 1'b1;
              end else if (voice_gate[i] && (age[i] != AGE_MAX)) begin
                age[i] <= age[i] + 1'b1;
              end
            end
          end else if (match_ok) begin
            voice_gate[match_idx] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
